// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter, the fetch unit and the loader.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_LOCKED = 2'd1,
      ST_YIELD  = 2'd2
   } state_e;

   localparam logic OWNER_FETCH  = 1'b0;
   localparam logic OWNER_LOADER = 1'b1;

   // Response tag captured on accept and consumed one cycle later
   typedef struct packed {
      logic valid;
      logic owner;
      logic err;
      logic wr;
   } rsp_tag_t;

   function automatic int unsigned idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Byte address to word index, flagging misaligned or out-of-range addresses.
module imem_addr_check
   import imem_pkg::*;
#(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DEPTH  = 1024,
   localparam int unsigned IDX_W  = idx_w(DEPTH)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              err
);

   logic [ADDR_W-3:0] word;

   always_comb begin
      word = addr[ADDR_W-1:2];
      idx  = word[IDX_W-1:0];
      err  = (addr[1:0] != 2'b00) || (word >= (ADDR_W-2)'(DEPTH));
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory between fetch and loader,
// with a bounded loader lock and a one-cycle tagged response path.
module imem_port_arbiter
   import imem_pkg::*;
#(
   parameter  int unsigned ADDR_W   = 32,
   parameter  int unsigned DATA_W   = 32,
   parameter  int unsigned DEPTH    = 1024,
   parameter  int unsigned MAX_LOCK = 64,
   localparam int unsigned IDX_W    = idx_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req_valid,
   output logic              f_req_ready,
   input  logic [ADDR_W-1:0] f_req_addr,
   output logic              f_rsp_valid,
   output logic [DATA_W-1:0] f_rsp_data,
   output logic              f_rsp_err,
   input  logic              l_req_valid,
   output logic              l_req_ready,
   input  logic              l_req_wr,
   input  logic [ADDR_W-1:0] l_req_addr,
   input  logic [DATA_W-1:0] l_req_wdata,
   input  logic              l_lock,
   output logic              l_rsp_valid,
   output logic [DATA_W-1:0] l_rsp_data,
   output logic              l_rsp_err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [IDX_W-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned LOCK_W = idx_w(MAX_LOCK + 1);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   rsp_tag_t          tag_q, tag_d;

   logic              grant_f, grant_l;
   logic [IDX_W-1:0]  f_idx, l_idx, acc_idx;
   logic              f_err, l_err, acc_err, accept, rd_ok;

   imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_f_check (
      .addr (f_req_addr),
      .idx  (f_idx),
      .err  (f_err)
   );

   imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_l_check (
      .addr (l_req_addr),
      .idx  (l_idx),
      .err  (l_err)
   );

   // Grant selection, lock sequencing and round-robin pointer
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_cnt_d   = lock_cnt_q;
      grant_f      = 1'b0;
      grant_l      = 1'b0;
      unique case (state_q)
         ST_ARB: begin
            if (f_req_valid && l_req_valid) begin
               grant_f = (last_grant_q == OWNER_LOADER);
               grant_l = !grant_f;
            end else begin
               grant_f = f_req_valid;
               grant_l = l_req_valid;
            end
            if (l_lock) begin
               state_d    = ST_LOCKED;
               lock_cnt_d = '0;
            end
         end
         ST_LOCKED: begin
            grant_l    = l_req_valid;
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            if (!l_lock) begin
               state_d = ST_ARB;
            end else if (lock_cnt_q == LOCK_W'(MAX_LOCK - 1)) begin
               state_d = ST_YIELD;
            end
         end
         ST_YIELD: begin
            grant_f    = f_req_valid;
            grant_l    = !f_req_valid && l_req_valid;
            lock_cnt_d = '0;
            state_d    = l_lock ? ST_LOCKED : ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
      if (grant_f) begin
         last_grant_d = OWNER_FETCH;
      end else if (grant_l) begin
         last_grant_d = OWNER_LOADER;
      end
   end

   // Memory strobes from the granted request; bad addresses never reach the memory
   always_comb begin
      accept    = grant_f || grant_l;
      acc_err   = grant_f ? f_err : l_err;
      acc_idx   = grant_f ? f_idx : l_idx;
      mem_en    = accept && !acc_err;
      mem_wr    = mem_en && grant_l && l_req_wr;
      mem_addr  = mem_en ? acc_idx : '0;
      mem_wdata = mem_wr ? l_req_wdata : '0;
      tag_d       = '0;
      tag_d.valid = accept;
      tag_d.owner = grant_l ? OWNER_LOADER : OWNER_FETCH;
      tag_d.err   = acc_err;
      tag_d.wr    = grant_l && l_req_wr;
   end

   always_comb begin
      f_req_ready = grant_f;
      l_req_ready = grant_l;
      rd_ok       = tag_q.valid && !tag_q.err && !tag_q.wr;
      f_rsp_valid = tag_q.valid && (tag_q.owner == OWNER_FETCH);
      l_rsp_valid = tag_q.valid && (tag_q.owner == OWNER_LOADER);
      f_rsp_err   = f_rsp_valid && tag_q.err;
      l_rsp_err   = l_rsp_valid && tag_q.err;
      f_rsp_data  = (f_rsp_valid && rd_ok) ? mem_rdata : '0;
      l_rsp_data  = (l_rsp_valid && rd_ok) ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARB;
         last_grant_q <= OWNER_LOADER;
         lock_cnt_q   <= '0;
         tag_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         tag_q        <= tag_d;
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Table-driven bench for imem_port_arbiter with a scoreboard of expected responses.
module tb_imem_port_arbiter;

   typedef struct {
      logic        fv;
      logic [31:0] fa;
      logic        lv;
      logic        lw;
      logic [31:0] la;
      logic [31:0] ld;
      logic        lk;
      logic        ef;
      logic        el;
   } vec_t;

   typedef struct packed {
      logic        owner;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err;
   logic [31:0] f_req_addr, f_rsp_data;
   logic        l_req_valid, l_req_ready, l_req_wr, l_lock, l_rsp_valid, l_rsp_err;
   logic [31:0] l_req_addr, l_req_wdata, l_rsp_data;
   logic        mem_en, mem_wr;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] mem [1024];
   logic        mem_ready = 1'b0;
   logic [31:0] shadow [1024];
   exp_t        sb [$];
   vec_t        tbl [$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   imem_port_arbiter #(.MAX_LOCK(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_req_valid (f_req_valid),
      .f_req_ready (f_req_ready),
      .f_req_addr  (f_req_addr),
      .f_rsp_valid (f_rsp_valid),
      .f_rsp_data  (f_rsp_data),
      .f_rsp_err   (f_rsp_err),
      .l_req_valid (l_req_valid),
      .l_req_ready (l_req_ready),
      .l_req_wr    (l_req_wr),
      .l_req_addr  (l_req_addr),
      .l_req_wdata (l_req_wdata),
      .l_lock      (l_lock),
      .l_rsp_valid (l_rsp_valid),
      .l_rsp_data  (l_rsp_data),
      .l_rsp_err   (l_rsp_err),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Synchronous memory: registered read, write visible to the next cycle's read
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
         mem_ready <= 1'b1;
      end else if (mem_en) begin
         if (mem_wr) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fv, input logic [31:0] fa, input logic lv,
                               input logic lw, input logic [31:0] la, input logic [31:0] ld,
                               input logic lk, input logic ef, input logic el);
      vec_t v;
      v.fv = fv; v.fa = fa; v.lv = lv; v.lw = lw; v.la = la; v.ld = ld;
      v.lk = lk; v.ef = ef; v.el = el;
      return v;
   endfunction

   task automatic check_rsp();
      exp_t e;
      logic fv, lv;
      logic [31:0] d;
      fv = 1'b0; lv = 1'b0; d = '0; e = '0;
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         fv = !e.owner;
         lv = e.owner;
         d  = e.data;
      end
      chk("f_rsp_valid", 32'(f_rsp_valid), 32'(fv));
      chk("l_rsp_valid", 32'(l_rsp_valid), 32'(lv));
      chk("f_rsp_data",  f_rsp_data, fv ? d : 32'h0);
      chk("l_rsp_data",  l_rsp_data, lv ? d : 32'h0);
      chk("f_rsp_err",   32'(f_rsp_err), 32'(fv && e.err));
      chk("l_rsp_err",   32'(l_rsp_err), 32'(lv && e.err));
   endtask

   // One cycle: drive at negedge, check grant/strobes, then the response after the edge
   task automatic step(input vec_t v);
      logic        acc, err, wr;
      logic [31:0] a;
      logic [9:0]  idx;
      exp_t        e;
      @(negedge clk);
      f_req_valid = v.fv; f_req_addr = v.fa;
      l_req_valid = v.lv; l_req_wr = v.lw; l_req_addr = v.la; l_req_wdata = v.ld;
      l_lock      = v.lk;
      #1;
      chk("f_req_ready", 32'(f_req_ready), 32'(v.ef));
      chk("l_req_ready", 32'(l_req_ready), 32'(v.el));
      acc = v.ef || v.el;
      a   = v.ef ? v.fa : v.la;
      wr  = v.el && v.lw;
      err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(1024));
      idx = a[11:2];
      chk("mem_en", 32'(mem_en), 32'(acc && !err));
      chk("mem_wr", 32'(mem_wr), 32'(acc && !err && wr));
      if (acc && !err) chk("mem_addr", 32'(mem_addr), 32'(idx));
      if (acc && !err && wr) chk("mem_wdata", mem_wdata, v.ld);
      if (acc) begin
         e.owner = v.el;
         e.err   = err;
         e.data  = (err || wr) ? 32'h0 : shadow[idx];
         sb.push_back(e);
         if (!err && wr) shadow[idx] = v.ld;
      end
      @(posedge clk);
      #1;
      check_rsp();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = 32'hA000_0000 | 32'(i);
      rst_n = 1'b0;
      f_req_valid = 1'b0; f_req_addr = '0;
      l_req_valid = 1'b0; l_req_wr = 1'b0; l_req_addr = '0; l_req_wdata = '0; l_lock = 1'b0;

      // fetch streaming, write-then-fetch, address errors, bounded lock
      tbl.push_back(mk(1, 32'h0,    0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(1, 32'h4,    0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(1, 32'h8,    0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 32'h0,    1, 1, 32'h10,   32'hDEADBEEF, 0, 0, 1));
      tbl.push_back(mk(1, 32'h10,   0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(1, 32'h6,    1, 0, 32'h1000, 32'h0,        0, 0, 1));
      tbl.push_back(mk(1, 32'h6,    0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(1, 32'hFFC,  0, 0, 32'h0,    32'h0,        0, 1, 0));
      tbl.push_back(mk(0, 32'h0,    1, 1, 32'h2,    32'h1234,     0, 0, 1));
      tbl.push_back(mk(1, 32'h20,   1, 0, 32'h24,   32'h0,        1, 1, 0));
      tbl.push_back(mk(1, 32'h20,   1, 0, 32'h28,   32'h0,        1, 0, 1));
      tbl.push_back(mk(1, 32'h20,   1, 0, 32'h2C,   32'h0,        1, 0, 1));
      tbl.push_back(mk(1, 32'h20,   0, 0, 32'h0,    32'h0,        1, 0, 0));
      tbl.push_back(mk(1, 32'h20,   1, 0, 32'h30,   32'h0,        1, 0, 1));
      tbl.push_back(mk(1, 32'h20,   1, 0, 32'h34,   32'h0,        1, 1, 0));
      tbl.push_back(mk(1, 32'h24,   1, 0, 32'h38,   32'h0,        1, 0, 1));
      tbl.push_back(mk(1, 32'h24,   1, 0, 32'h3C,   32'h0,        0, 0, 1));
      tbl.push_back(mk(1, 32'h24,   1, 0, 32'h40,   32'h0,        0, 1, 0));
      tbl.push_back(mk(0, 32'h0,    1, 0, 32'h40,   32'h0,        1, 0, 1));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 32'h0, 1, 0, 32'h44 + 32'(4 * i), 32'h0, 1, 0, 1));
      tbl.push_back(mk(0, 32'h0,    1, 0, 32'h54,   32'h0,        1, 0, 1));
      tbl.push_back(mk(1, 32'h58,   1, 0, 32'h5C,   32'h0,        1, 0, 1));
      tbl.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0));
      tbl.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst f_rsp_valid", 32'(f_rsp_valid), 32'h0);
      chk("rst l_rsp_valid", 32'(l_rsp_valid), 32'h0);
      chk("rst mem_en",      32'(mem_en),      32'h0);
      chk("rst mem_wr",      32'(mem_wr),      32'h0);
      chk("rst f_rsp_data",  f_rsp_data,       32'h0);
      chk("rst l_rsp_data",  l_rsp_data,       32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i]);

      // Reset while a read is in flight: its response must be dropped
      step(mk(1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 1, 0));
      @(negedge clk);
      f_req_valid = 1'b1; f_req_addr = 32'h8;
      #1;
      chk("mid f_req_ready", 32'(f_req_ready), 32'h1);
      rst_n = 1'b0;
      f_req_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("mid f_rsp_valid", 32'(f_rsp_valid), 32'h0);
         chk("mid l_rsp_valid", 32'(l_rsp_valid), 32'h0);
         chk("mid mem_en",      32'(mem_en),      32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Both requesters busy after reset: fetch wins the first tie, then alternate
      step(mk(1, 32'hC, 1, 0, 32'h14, 32'h0, 0, 1, 0));
      step(mk(1, 32'hC, 1, 0, 32'h14, 32'h0, 0, 0, 1));
      step(mk(1, 32'hC, 1, 0, 32'h14, 32'h0, 0, 1, 0));
      step(mk(1, 32'hC, 1, 0, 32'h14, 32'h0, 0, 0, 1));
      step(mk(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
